// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding, owner codes
// and the two-way pick rule used by the arbitration sub-module.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  // Winner of a two-way request: a lone requester always wins; a tie goes to
  // the loader in fixed mode, otherwise to whoever the pointer names.
  function automatic logic pick(input logic cpu_req, input logic ld_req,
                                input logic ptr, input logic fixed);
    logic w;
    if (cpu_req && ld_req) begin
      w = fixed ? OWN_LD : ptr;
    end else if (ld_req) begin
      w = OWN_LD;
    end else begin
      w = OWN_CPU;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr2.sv
// arb_rr2: two-way round-robin / fixed-priority pick.
// Combinational winner; the preference pointer is registered and moves to
// the non-owner when the top signals that a transaction has finished.
module arb_rr2
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic ld_req,
  input  logic done,
  input  logic done_owner,
  output logic winner
);

  logic ptr;

  // Preference pointer: CPU preferred after reset, then the party that did
  // not just finish gets the next tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= OWN_CPU;
    end else if (done) begin
      ptr <= ~done_owner;
    end
  end

  // Winner selection from the current requests and pointer.
  always_comb begin
    winner = pick(cpu_req, ld_req, ptr, FIXED_PRIO != 0);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates CPU and loader access to a single-port RAM and
// sequences each access (IDLE -> ACCESS x ACCESS_CYCLES -> DONE).
// Optional burst lock: define MEM_ARB_LOCK_EN to add cpu_lock/ld_lock, which
// let the current owner keep the RAM across consecutive transactions.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter int FIXED_PRIO    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
`ifdef MEM_ARB_LOCK_EN
  input  logic              cpu_lock,
  input  logic              ld_lock,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_oe,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_halt,
  output logic              owner,
  output logic              busy
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               xact_we_reg, xact_we_next;
  logic               owner_next, busy_next, halt_next;
  logic               ram_we_next, ram_oe_next;
  logic [ADDR_W-1:0]  ram_addr_next;
  logic [DATA_W-1:0]  ram_wdata_next, rdata_next;
  logic               cpu_ack_next, ld_ack_next;
  logic               grant, done_strobe, winner, lock_hit;
  logic               sel_owner, sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .ld_req     (ld_req),
    .done       (done_strobe),
    .done_owner (owner),
    .winner     (winner)
  );

`ifdef MEM_ARB_LOCK_EN
  assign lock_hit = (owner == OWN_LD) ? ld_lock : cpu_lock;
`else
  assign lock_hit = 1'b0;
`endif

  // In IDLE the arbiter's winner is granted; a locked regrant in DONE keeps
  // the current owner. Either way the owner's request fields are latched.
  assign sel_owner = (state_reg == IDLE) ? winner : owner;
  assign sel_we    = (sel_owner == OWN_LD) ? ld_we    : cpu_we;
  assign sel_addr  = (sel_owner == OWN_LD) ? ld_addr  : cpu_addr;
  assign sel_wdata = (sel_owner == OWN_LD) ? ld_wdata : cpu_wdata;

  // State and output registers; every output is a flop so no request path
  // reaches the RAM pins combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      xact_we_reg <= 1'b0;
      owner       <= OWN_CPU;
      busy        <= 1'b0;
      cpu_halt    <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      rdata       <= '0;
      cpu_ack     <= 1'b0;
      ld_ack      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      xact_we_reg <= xact_we_next;
      owner       <= owner_next;
      busy        <= busy_next;
      cpu_halt    <= halt_next;
      ram_we      <= ram_we_next;
      ram_oe      <= ram_oe_next;
      ram_addr    <= ram_addr_next;
      ram_wdata   <= ram_wdata_next;
      rdata       <= rdata_next;
      cpu_ack     <= cpu_ack_next;
      ld_ack      <= ld_ack_next;
    end
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    xact_we_next   = xact_we_reg;
    owner_next     = owner;
    busy_next      = busy;
    halt_next      = cpu_halt;
    ram_we_next    = ram_we;
    ram_oe_next    = ram_oe;
    ram_addr_next  = ram_addr;
    ram_wdata_next = ram_wdata;
    rdata_next     = rdata;
    cpu_ack_next   = 1'b0;
    ld_ack_next    = 1'b0;
    grant          = 1'b0;
    done_strobe    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cpu_req || ld_req) begin
          grant = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_reg == CNT_LAST) begin
          state_next  = DONE;
          ram_we_next = 1'b0;
          ram_oe_next = 1'b0;
          if (!xact_we_reg) begin
            rdata_next = ram_rdata;
          end
          cpu_ack_next = (owner == OWN_CPU);
          ld_ack_next  = (owner == OWN_LD);
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (lock_hit) begin
          grant = 1'b1;
        end else begin
          state_next  = IDLE;
          busy_next   = 1'b0;
          halt_next   = 1'b0;
          done_strobe = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (grant) begin
      state_next     = ACCESS;
      cnt_next       = '0;
      owner_next     = sel_owner;
      xact_we_next   = sel_we;
      ram_addr_next  = sel_addr;
      ram_wdata_next = sel_wdata;
      ram_we_next    = sel_we;
      ram_oe_next    = ~sel_we;
      busy_next      = 1'b1;
      halt_next      = (sel_owner == OWN_LD);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table-driven vectors, randomized transactions
// against a transaction-level reference model, and hand-written sequences for
// input changes during access, asynchronous reset, contention and burst lock.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AC = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, ld_addr = 0, ld_wdata = 0;
  logic       cpu_ack, ld_ack, ram_we, ram_oe, cpu_halt, owner, busy;
  logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;
`ifdef MEM_ARB_LOCK_EN
  logic       cpu_lock = 0, ld_lock = 0;
`endif

  // Second instance in fixed-priority mode, fed only with tie requests.
  logic       fp_cpu_req = 0, fp_ld_req = 0;
  logic       fp_cpu_ack, fp_ld_ack, fp_ram_we, fp_ram_oe, fp_cpu_halt, fp_owner, fp_busy;
  logic [7:0] fp_rdata, fp_ram_addr, fp_ram_wdata;
  logic [7:0] zero8 = 8'h00;
  logic       zero1 = 1'b0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(AC), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
`ifdef MEM_ARB_LOCK_EN
    .cpu_lock(cpu_lock), .ld_lock(ld_lock),
`endif
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_rdata(ram_rdata), .cpu_halt(cpu_halt), .owner(owner), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(AC), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .cpu_req(fp_cpu_req), .cpu_we(zero1), .cpu_addr(zero8), .cpu_wdata(zero8), .cpu_ack(fp_cpu_ack),
    .ld_req(fp_ld_req), .ld_we(zero1), .ld_addr(zero8), .ld_wdata(zero8), .ld_ack(fp_ld_ack),
`ifdef MEM_ARB_LOCK_EN
    .cpu_lock(zero1), .ld_lock(zero1),
`endif
    .rdata(fp_rdata), .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata), .ram_we(fp_ram_we), .ram_oe(fp_ram_oe),
    .ram_rdata(zero8), .cpu_halt(fp_cpu_halt), .owner(fp_owner), .busy(fp_busy)
  );

  // RAM behind the main arbiter: asynchronous read, synchronous write.
  logic [7:0] ram [256];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [7:0] ref_mem [256];
  logic       pref_ld = 1'b0;   // who wins the next tie
  logic [7:0] last_rd = 8'h00;  // value rdata should hold

  task automatic model(input logic cen, cwe, input logic [7:0] caddr, cwdata,
                       input logic len, lwe, input logic [7:0] laddr, lwdata,
                       output logic m_first_ld, output logic [7:0] m_crd, m_lrd);
    logic who;
    m_first_ld = (cen && len) ? pref_ld : len;
    m_crd = 8'h00;
    m_lrd = 8'h00;
    for (int k = 0; k < 2; k++) begin
      who = (k == 0) ? m_first_ld : !m_first_ld;
      if (who ? len : cen) begin
        if (who) begin
          if (lwe) ref_mem[laddr] = lwdata; else last_rd = ref_mem[laddr];
          m_lrd = last_rd;
        end else begin
          if (cwe) ref_mem[caddr] = cwdata; else last_rd = ref_mem[caddr];
          m_crd = last_rd;
        end
        pref_ld = !who;
      end
    end
  endtask

  // ---------------- transaction driver ----------------
  logic       r_first_ld, r_timeout;
  logic [7:0] r_crd, r_lrd;
  int         r_ccyc, r_lcyc, r_strobe, r_halt;

  task automatic run_xact(input logic cen, cwe, input logic [7:0] caddr, cwdata,
                          input logic len, lwe, input logic [7:0] laddr, lwdata);
    bit pc, pl, dc, dl, got;
    int cyc;
    cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwdata; cpu_req = cen;
    ld_we = lwe;  ld_addr = laddr;  ld_wdata = lwdata;  ld_req = len;
    pc = cen; pl = len; dc = 0; dl = 0; got = 0; cyc = 0;
    r_strobe = 0; r_halt = 0; r_ccyc = 0; r_lcyc = 0; r_first_ld = 0; r_timeout = 0;
    r_crd = 8'h00; r_lrd = 8'h00;
    while ((pc || pl || dc || dl) && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (dc) begin cpu_req = 0; dc = 0; end
      if (dl) begin ld_req = 0; dl = 0; end
      if (ram_we || ram_oe) r_strobe++;
      if (cpu_halt) r_halt++;
      if (cpu_ack) begin
        if (!pc) chk("cpu_ack_extra", cpu_ack, 0);
        else begin
          pc = 0; dc = 1; r_ccyc = cyc; r_crd = rdata;
          if (!got) begin got = 1; r_first_ld = 0; end
        end
      end
      if (ld_ack) begin
        if (!pl) chk("ld_ack_extra", ld_ack, 0);
        else begin
          pl = 0; dl = 1; r_lcyc = cyc; r_lrd = rdata;
          if (!got) begin got = 1; r_first_ld = 1; end
        end
      end
    end
    r_timeout = pc || pl;
  endtask

  task automatic check_result(input string tag, input logic cen, len, input logic efirst_ld,
                              input logic [7:0] ecrd, elrd, input logic ccrd, clrd);
    int n;
    n = int'(cen) + int'(len);
    chk({tag, "_timeout"}, r_timeout, 0);
    if (cen && len) chk({tag, "_first"}, r_first_ld, efirst_ld);
    if (cen) chk({tag, "_cpu_lat"}, r_ccyc, (len && efirst_ld) ? 2*AC+3 : AC+1);
    if (len) chk({tag, "_ld_lat"}, r_lcyc, (cen && !efirst_ld) ? 2*AC+3 : AC+1);
    chk({tag, "_strobe"}, r_strobe, AC*n);
    chk({tag, "_halt"}, r_halt, len ? AC+1 : 0);
    if (ccrd) chk({tag, "_cpu_rdata"}, r_crd, ecrd);
    if (clrd) chk({tag, "_ld_rdata"}, r_lrd, elrd);
    $display("xact %s: cpu=%0b ld=%0b first_ld=%0b cpu_rd=%02h ld_rd=%02h lat=%0d/%0d",
             tag, cen, len, r_first_ld, r_crd, r_lrd, r_ccyc, r_lcyc);
  endtask

  typedef struct {
    logic       cen, cwe;
    logic [7:0] caddr, cwdata;
    logic       len, lwe;
    logic [7:0] laddr, lwdata;
    logic       exp_first_ld;
    logic [7:0] exp_crd, exp_lrd;
  } vec_t;

  vec_t       tbl [10];
  logic       m_first;
  logic [7:0] m_crd, m_lrd;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Hand-derived vectors, starting from the post-reset pointer (CPU preferred).
    tbl[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C, 1'b1, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h3C, 8'h00};
    tbl[4] = '{1'b1, 1'b1, 8'h30, 8'h55, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h00, 8'hA5};
    tbl[5] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 8'h31, 8'h77, 1'b1, 8'h55, 8'h00};
    tbl[6] = '{1'b1, 1'b0, 8'h31, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h77, 8'h3C};
    tbl[7] = '{1'b1, 1'b1, 8'h32, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 8'h00, 8'h55};
    tbl[9] = '{1'b1, 1'b0, 8'h32, 8'h00, 1'b1, 1'b1, 8'h33, 8'h11, 1'b0, 8'h99, 8'h00};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {cpu_ack, ld_ack, rdata, ram_addr, ram_wdata, ram_we, ram_oe, cpu_halt, owner, busy}, 0);
    @(negedge clk) reset = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      model(tbl[i].cen, tbl[i].cwe, tbl[i].caddr, tbl[i].cwdata,
            tbl[i].len, tbl[i].lwe, tbl[i].laddr, tbl[i].lwdata, m_first, m_crd, m_lrd);
      run_xact(tbl[i].cen, tbl[i].cwe, tbl[i].caddr, tbl[i].cwdata,
               tbl[i].len, tbl[i].lwe, tbl[i].laddr, tbl[i].lwdata);
      check_result($sformatf("tbl%0d", i), tbl[i].cen, tbl[i].len, tbl[i].exp_first_ld,
                   tbl[i].exp_crd, tbl[i].exp_lrd, tbl[i].cen && !tbl[i].cwe, tbl[i].len && !tbl[i].lwe);
    end

    // Seed the random address window with known contents via loader writes.
    for (int a = 8'h40; a < 8'h48; a++) begin
      logic [7:0] d;
      d = 8'($urandom);
      model(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'(a), d, m_first, m_crd, m_lrd);
      run_xact(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'(a), d);
      check_result($sformatf("seed%0h", a), 1'b0, 1'b1, m_first, m_crd, m_lrd, 1'b0, 1'b1);
    end

    // Randomized transactions checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic       cen, cwe, len, lwe;
      logic [7:0] ca, cd, la, ld;
      int         sel;
      sel = $urandom_range(0, 2);
      cen = (sel != 1); len = (sel != 0);
      cwe = 1'($urandom); lwe = 1'($urandom);
      ca = 8'($urandom_range(8'h40, 8'h47)); la = 8'($urandom_range(8'h40, 8'h47));
      cd = 8'($urandom); ld = 8'($urandom);
      model(cen, cwe, ca, cd, len, lwe, la, ld, m_first, m_crd, m_lrd);
      run_xact(cen, cwe, ca, cd, len, lwe, la, ld);
      check_result($sformatf("rnd%0d", i), cen, len, m_first, m_crd, m_lrd, cen, len);
    end

    // CPU address changes during ACCESS: the latched address must be used.
    cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1; ld_req = 0;
    @(posedge clk); #1; cpu_addr = 8'h11;
    chk("chg_addr_c1", ram_addr, 8'h10);
    @(posedge clk); #1;
    chk("chg_addr_c2", ram_addr, 8'h10);
    @(posedge clk); #1;
    chk("chg_ack", cpu_ack, 1);
    chk("chg_rdata", rdata, ref_mem[8'h10]);
    $display("xact chg: cpu read 0x10 with address changed mid-access, rdata=%02h", rdata);
    @(posedge clk); #1; cpu_req = 0;
    pref_ld = 1'b1; last_rd = ref_mem[8'h10];

    // Asynchronous reset in the second ACCESS cycle of a loader write.
    begin
      int acks;
      ld_we = 1; ld_addr = 8'h50; ld_wdata = 8'hEE; ld_req = 1;
      @(posedge clk); #1;
      chk("rst_pre_halt", cpu_halt, 1);
      @(posedge clk); #1;
      chk("rst_pre_we", ram_we, 1);
      reset = 1'b0;
      #1;
      chk("rst_we", ram_we, 0);
      chk("rst_oe", ram_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halt", cpu_halt, 0);
      acks = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (ld_ack || cpu_ack) acks++;
      end
      chk("rst_no_ack", acks, 0);
      ld_req = 0;
      @(negedge clk) reset = 1'b1;
      pref_ld = 1'b0; last_rd = 8'h00;
      $display("xact rst: loader write aborted by reset");
    end

    // Constant contention: round-robin alternates; fixed priority favours loader.
    begin
      int n, cyc, fpc, fpl;
      logic exp_ld;
      cpu_we = 0; cpu_addr = 8'h10; ld_we = 0; ld_addr = 8'h20;
      cpu_req = 1; ld_req = 1; fp_cpu_req = 1; fp_ld_req = 1;
      n = 0; cyc = 0; fpc = 0; fpl = 0;
      while (n < 4 && cyc < 40) begin
        @(posedge clk); #1; cyc++;
        if (fp_cpu_ack) fpc++;
        if (fp_ld_ack) fpl++;
        if (cpu_ack || ld_ack) begin
          exp_ld = pref_ld;
          pref_ld = !exp_ld;
          last_rd = exp_ld ? ref_mem[8'h20] : ref_mem[8'h10];
          chk($sformatf("contend_order%0d", n), ld_ack, exp_ld);
          chk($sformatf("contend_rdata%0d", n), rdata, last_rd);
          $display("xact contend%0d: owner_ld=%0b rdata=%02h", n, ld_ack, rdata);
          n++;
        end
      end
      chk("contend_count", n, 4);
      chk("fp_cpu_acks", fpc, 0);
      chk("fp_ld_acks", fpl, 4);
      @(posedge clk); #1;
      cpu_req = 0; ld_req = 0; fp_cpu_req = 0; fp_ld_req = 0;
      repeat (3) @(posedge clk);
      #1;
    end

`ifdef MEM_ARB_LOCK_EN
    // Locked loader burst of four writes while the CPU waits.
    begin
      int nl, cyc, halt_drop, cpu_early, cw;
      logic got_cpu;
      ld_lock = 1; ld_we = 1; ld_addr = 8'h00; ld_wdata = 8'hC0; ld_req = 1;
      @(posedge clk); #1;
      cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1;
      nl = 0; cyc = 0; halt_drop = 0; cpu_early = 0;
      while (nl < 4 && cyc < 40) begin
        if (!cpu_halt) halt_drop++;
        if (cpu_ack) cpu_early++;
        if (ld_ack) begin
          nl++;
          ld_addr = 8'(nl); ld_wdata = 8'hC0 + 8'(nl);
          if (nl == 4) ld_lock = 0;
        end
        @(posedge clk); #1; cyc++;
      end
      ld_req = 0;
      chk("lock_ld_acks", nl, 4);
      chk("lock_cpu_early", cpu_early, 0);
      chk("lock_halt_gap", halt_drop, 0);
      got_cpu = 0; cw = 0;
      while (!got_cpu && cw < 10) begin
        @(posedge clk); #1; cw++;
        if (cpu_ack) got_cpu = 1;
      end
      chk("lock_cpu_after", got_cpu, 1);
      chk("lock_mem1", ram[1], 8'hC1);
      chk("lock_mem3", ram[3], 8'hC3);
      $display("xact lock: %0d locked loader writes then cpu ack=%0b", nl, got_cpu);
      @(posedge clk); #1; cpu_req = 0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and access sequencer for the single-port 8-bit program/data RAM. The CPU memory path (MAR/RAM-out/RAM-in control) and a program loader/DMA port both issue req/ack transactions. The arbiter picks a winner and latches its address, write enable and write data. It then drives the RAM port for a fixed number of cycles and returns read data with a one-cycle ack. While the loader owns the RAM it raises cpu_halt, which feeds the clock block's halt input.

Parameters:
ADDR_W, 8, address width (matches address bus)
DATA_W, 8, data width (matches data bus)
ACCESS_CYCLES, 2, cycles ram_oe/ram_we held per transaction (>=1)
FIXED_PRIO, 0, 0 = round-robin; 1 = loader always wins ties

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU transaction request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
ld_req  in  1  loader request, held until ld_ack
ld_we  in  1  loader write enable
ld_addr  in  ADDR_W  loader address
ld_wdata  in  DATA_W  loader write data
ld_ack  out  1  one-cycle completion pulse to loader
rdata  out  DATA_W  read data, valid in ack cycle, held until next ack
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write strobe
ram_oe  out  1  RAM output enable
ram_rdata  in  DATA_W  RAM read data
cpu_halt  out  1  high while loader owns the RAM
owner  out  1  0 = CPU, 1 = loader (valid when busy)
busy  out  1  high in ACCESS/DONE

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; rr pointer = CPU preferred; access counter 0. Reset mid-access drops ram_we/ram_oe immediately; no ack is issued.
- All outputs are registered; no combinational path from req to RAM signals.
- IDLE:
  - Neither request: stay.
  - One request: grant it.
  - Both requests: FIXED_PRIO=1 grants the loader; otherwise grant the requester the rr pointer names.
  - On grant: latch we/addr/wdata into ram_* and set owner. Assert ram_oe (read) or ram_we (write), plus busy. Go to ACCESS; counter = 0.
- ACCESS:
  - Strobe held for ACCESS_CYCLES cycles; counter increments each cycle.
  - Requester inputs are ignored (latched values used).
  - In the last cycle, read transactions capture ram_rdata into rdata.
  - Then go to DONE.
- DONE (1 cycle):
  - ram_we/ram_oe = 0; ack pulses to owner; busy stays 1.
  - rr pointer moves to the non-owner.
  - Return to IDLE.
- Latency: request high at edge N → strobes active from N+1 → ack in cycle N+1+ACCESS_CYCLES. Total per transaction = ACCESS_CYCLES+2 cycles.
- Requesters drop req in the cycle after ack. A req still high in IDLE starts a new transaction (back-to-back allowed, subject to arbitration).
- Write transactions leave rdata unchanged.
- cpu_halt = 1 from the grant edge to the end of DONE when owner = loader; 0 otherwise.
- Round-robin guarantees that, under constant contention, transactions alternate CPU, loader, CPU, ...
- Request dropped before ack is a protocol violation; the arbiter still completes the transaction.

Optional Feature:
MEM_ARB_LOCK_EN
- Enabled: adds inputs cpu_lock and ld_lock. If the owner's lock is high in DONE, the arbiter skips IDLE arbitration and the rr update, and regrants the same owner. The next transaction's request fields are latched in DONE and ACCESS starts on the following cycle. This allows burst program load without interleaving; cpu_halt stays high through the whole burst.
- Disabled: no lock ports; behaviour as above.

Decomposition:
- Shared package/header (alongside symbols.vh): state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), owner codes (OWN_CPU=0, OWN_LD=1).
- One sub-module: arb_rr2, the two-way round-robin/fixed-priority pick. Combinational winner plus registered pointer, with the pointer updated on a done strobe.

Test Plan:
- CPU read: memory[0x10]=0xA5; cpu_req=1, cpu_we=0, cpu_addr=0x10 → ram_oe for 2 cycles; cpu_ack in cycle 3 after request; rdata=0xA5; cpu_halt stays 0.
- Loader write: ld_req=1, ld_we=1, ld_addr=0x20, ld_wdata=0x3C → ram_we for 2 cycles; ld_ack once; cpu_halt=1 for 3 cycles; subsequent CPU read of 0x20 returns 0x3C.
- Contention: cpu_req and ld_req both held, FIXED_PRIO=0 → ack order CPU, loader, CPU, loader; with FIXED_PRIO=1 the loader wins every tie.
- Input change: cpu_addr changed from 0x10 to 0x11 during ACCESS → RAM still sees 0x10; rdata = mem[0x10].
- Async reset: reset=0 in the second ACCESS cycle → ram_we/ram_oe/busy/cpu_halt fall without waiting for clk; no ack; after release, a new request completes normally.
- MEM_ARB_LOCK_EN: ld_lock=1 for 4 writes to 0x00..0x03 while cpu_req is held → four consecutive ld_acks before the first cpu_ack; cpu_halt continuous.
